// File: rtl/spi_pkg.sv
// Shared types for the SPI byte-stream transfer controller.
//   spi_byte_t   : one SPI data byte
//   xfer_state_t : transfer sequencer states
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef logic [SPI_BYTE_W-1:0] spi_byte_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE,
    HOLD
  } xfer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read/write pointers carrying one extra
// wrap bit. The head entry is shown combinationally on dout.
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push, din  : write request and data
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   full/empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A push into a full FIFO is still taken when the same cycle frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign dout = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Byte-stream transfer controller in front of the SPI shift engine.
// Software queues bytes in a TX FIFO; each byte becomes one SPI transfer and
// the received byte lands in an RX FIFO. Chip select is asserted around a
// burst with programmable setup and hold.
//   clk, rst_n            : clock, asynchronous active-low reset
//   wr_en, wr_data        : TX push (ignored when tx_full)
//   rd_en, rd_data        : RX pop / RX head
//   tx_full, rx_empty     : FIFO flags
//   busy                  : sequencer active or TX bytes pending
//   rx_ovf, ovf_clr       : sticky RX drop flag and its clear
//   cs_n                  : chip select, active low
//   spi_tx_start/_data    : start pulse and byte to the shift engine
//   spi_tx_ready/rx_data  : engine idle/done and received byte
//
// state     | meaning
// IDLE      | cs_n high, waiting for TX data
// SETUP     | cs_n low, counting CS_SETUP before the first byte
// START     | start pulse high, byte presented to the engine
// WAIT_BUSY | waiting for the engine to accept (ready low)
// WAIT_DONE | waiting for the engine to finish (ready high)
// CAPTURE   | storing the received byte
// HOLD      | cs_n low, counting CS_HOLD; new TX data restarts a byte
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       tx_full,
  output logic       rx_empty,
  output logic       busy,
  output logic       rx_ovf,
  input  logic       ovf_clr,
  output logic       cs_n,
  output logic       spi_tx_start,
  output logic [7:0] spi_tx_data,
  input  logic       spi_tx_ready,
  input  logic [7:0] spi_rx_data
);

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);

  xfer_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  spi_byte_t tx_dout;
  logic      tx_empty;
  logic      tx_push;
  logic      tx_pop;
  logic      rx_full;
  logic      rx_push;
  logic      ovf_set;

  assign tx_push = wr_en & ~tx_full;
  // The head byte is copied into spi_tx_data on entry to START and released
  // from the FIFO when START ends, so the slot stays occupied for the pulse.
  assign tx_pop  = (state_q == START);
  assign rx_push = (state_q == CAPTURE);
  assign ovf_set = rx_push & rx_full & ~rd_en;

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .din   (wr_data),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .din   (spi_rx_data),
    .pop   (rd_en),
    .dout  (rd_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!tx_empty) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_q != '0)       cnt_d   = cnt_q - CNT_W'(1);
        else if (spi_tx_ready) state_d = START;
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!spi_tx_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (spi_tx_ready)  state_d = CAPTURE;
      CAPTURE: begin
        if (!tx_empty) begin
          state_d = START;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      HOLD: begin
        if (!tx_empty)         state_d = START;
        else if (cnt_q != '0)  cnt_d   = cnt_q - CNT_W'(1);
        else                   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cs_n         <= 1'b1;
      spi_tx_start <= 1'b0;
      spi_tx_data  <= '0;
      busy         <= 1'b0;
      rx_ovf       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cs_n         <= (state_d == IDLE);
      spi_tx_start <= (state_d == START);
      if (state_d == START) spi_tx_data <= tx_dout;
      // Looks ahead at this cycle's push so busy rises right after wr_en.
      busy         <= (state_d != IDLE) | ~tx_empty | tx_push;
      rx_ovf       <= ovf_set | (rx_ovf & ~ovf_clr);
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
module tb_spi_xfer_ctrl;

  localparam int DEPTH    = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_en = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       spi_tx_ready = 1'b1;
  logic [7:0] spi_rx_data = 8'h00;
  logic [7:0] rd_data;
  logic [7:0] spi_tx_data;
  logic       tx_full, rx_empty, busy, rx_ovf, cs_n, spi_tx_start;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(.FIFO_DEPTH(DEPTH), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .tx_full      (tx_full),
    .rx_empty     (rx_empty),
    .busy         (busy),
    .rx_ovf       (rx_ovf),
    .ovf_clr      (ovf_clr),
    .cs_n         (cs_n),
    .spi_tx_start (spi_tx_start),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_ready (spi_tx_ready),
    .spi_rx_data  (spi_rx_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (queue/occupancy level) ----------------
  logic [7:0] exp_tx_q[$];
  logic [7:0] rx_q[$];
  int         tx_occ;
  int         cap_cd;
  logic [7:0] cap_byte;
  logic       exp_ovf;
  logic       prev_start;
  logic       prev_cs;
  int         n_starts;
  int         cs_falls;

  task automatic model_reset();
    exp_tx_q.delete();
    rx_q.delete();
    tx_occ     = 0;
    cap_cd     = 0;
    exp_ovf    = 1'b0;
    prev_start = 1'b0;
    prev_cs    = 1'b1;
  endtask

  // One clock: advance to just after the edge, apply that edge's events to
  // the model, then compare visible FIFO/flag state.
  task automatic step();
    logic pop_tx, acc, rpop, cap, ovf_set;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pop_tx = prev_start;
    acc    = wr_en && (tx_occ < DEPTH);
    if (acc) begin
      tx_occ++;
      exp_tx_q.push_back(wr_data);
    end
    if (pop_tx) tx_occ--;
    rpop = rd_en && (rx_q.size() > 0);
    if (rpop) void'(rx_q.pop_front());
    cap = 1'b0;
    if (cap_cd > 0) begin
      cap_cd--;
      cap = (cap_cd == 0);
    end
    ovf_set = 1'b0;
    if (cap) begin
      if (rx_q.size() < DEPTH) rx_q.push_back(cap_byte);
      else ovf_set = 1'b1;
    end
    exp_ovf = ovf_set | (exp_ovf & ~ovf_clr);
    if (prev_cs && !cs_n) cs_falls++;
    prev_cs    = cs_n;
    prev_start = spi_tx_start;
    chk("tx_full", tx_full, (tx_occ == DEPTH));
    chk("rx_empty", rx_empty, (rx_q.size() == 0));
    if (rx_q.size() > 0) chk("rd_data", rd_data, rx_q[0]);
    chk("rx_ovf", rx_ovf, exp_ovf);
  endtask

  // ---------------- SPI engine model ----------------
  logic [7:0] resp [3] = '{8'hDE, 8'h5A, 8'hFF};
  int         resp_idx = 0;
  int         slv_cnt = 0;
  logic       slv_busy = 1'b0;
  logic [7:0] slv_byte = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        slv_busy     = 1'b0;
        spi_tx_ready = 1'b1;
      end else if (slv_busy) begin
        chk("tx_data_stable", spi_tx_data, slv_byte);
        chk("start_one_cycle", spi_tx_start, 1'b0);
        chk("cs_low_in_xfer", cs_n, 1'b0);
        slv_cnt--;
        if (slv_cnt == 0) begin
          spi_rx_data  = resp[resp_idx % 3];
          cap_byte     = spi_rx_data;
          resp_idx++;
          spi_tx_ready = 1'b1;
          cap_cd       = 2;
          slv_busy     = 1'b0;
        end
      end else if (spi_tx_start) begin
        n_starts++;
        slv_byte = spi_tx_data;
        chk("cs_low_at_start", cs_n, 1'b0);
        if (exp_tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start: byte %0h with no queued byte", spi_tx_data);
        end else begin
          chk("tx_byte", spi_tx_data, exp_tx_q.pop_front());
        end
        slv_busy     = 1'b1;
        spi_tx_ready = 1'b0;
        slv_cnt      = $urandom_range(2, 8);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 3000) begin
      step();
      k++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic pop_all(output int n);
    n = 0;
    while (!rx_empty && n < 10) begin
      rd_en = 1'b1;
      step();
      n++;
    end
    rd_en = 1'b0;
  endtask

  typedef struct {
    int             n;
    logic [4:0][7:0] d;
    int             exp_starts;
    int             exp_rx;
    int             exp_cs;
  } row_t;

  row_t rows[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, s0, c0;
    rows[0] = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'hA5}, 1, 1, 1};
    rows[1] = '{5, {8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, 4, 4, 1};
    rows[2] = '{3, {8'h00, 8'h00, 8'h95, 8'h00, 8'h40}, 3, 3, 1};
    rows[3] = '{4, {8'h00, 8'h55, 8'hAA, 8'h0F, 8'hF0}, 4, 4, 1};
    n_starts = 0;
    cs_falls = 0;
    model_reset();

    // Reset values
    #12;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_start", spi_tx_start, 1'b0);
    chk("rst_rx_empty", rx_empty, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_rx_ovf", rx_ovf, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_tx_data", spi_tx_data, 8'h00);
    #1 rst_n = 1'b1;
    step();
    step();

    // Single byte: setup/hold timing
    push_byte(8'hC5);
    chk("single_busy_rise", busy, 1'b1);
    chk("single_cs_before", cs_n, 1'b1);
    step();
    chk("single_cs_fall", cs_n, 1'b0);
    k = 0;
    while (!spi_tx_start && k < 20) begin
      step();
      k++;
    end
    chk("setup_cycles", k, CS_SETUP);
    chk("single_tx_data", spi_tx_data, 8'hC5);
    k = 0;
    while (rx_empty && k < 100) begin
      step();
      k++;
    end
    chk("single_rx_avail", rx_empty, 1'b0);
    chk("single_rd_data", rd_data, 8'hDE);
    k = 0;
    while (!cs_n && k < 20) begin
      step();
      k++;
    end
    chk("hold_cycles", k, CS_HOLD);
    chk("single_busy_fall", busy, 1'b0);
    pop_all(n);
    chk("single_pops", n, 1);

    // Table-driven bursts
    for (int r = 0; r < 4; r++) begin
      s0 = n_starts;
      c0 = cs_falls;
      for (int i = 0; i < rows[r].n; i++) begin
        wr_en   = 1'b1;
        wr_data = rows[r].d[i];
        step();
      end
      wr_en = 1'b0;
      wait_idle();
      step();
      chk("row_starts", n_starts - s0, rows[r].exp_starts);
      chk("row_cs_bursts", cs_falls - c0, rows[r].exp_cs);
      pop_all(n);
      chk("row_rx_count", n, rows[r].exp_rx);
      chk("row_ovf", rx_ovf, 1'b0);
    end

    // RX overflow: five transfers with no pops
    s0 = n_starts;
    for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
    k = 0;
    while (n_starts == s0 && k < 100) begin
      step();
      k++;
    end
    step();
    push_byte(8'h14);
    wait_idle();
    step();
    chk("ovf_starts", n_starts - s0, 5);
    chk("ovf_set", rx_ovf, 1'b1);
    pop_all(n);
    chk("ovf_rx_count", n, DEPTH);
    chk("ovf_sticky", rx_ovf, 1'b1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_cleared", rx_ovf, 1'b0);

    // HOLD re-entry: second byte pushed during hold keeps cs_n low
    s0 = n_starts;
    c0 = cs_falls;
    push_byte(8'h11);
    k = 0;
    while (rx_empty && k < 100) begin
      step();
      k++;
    end
    chk("hold_rx_avail", rx_empty, 1'b0);
    push_byte(8'h22);
    chk("hold_cs_kept", cs_n, 1'b0);
    step();
    chk("hold_restart", spi_tx_start, 1'b1);
    chk("hold_restart_data", spi_tx_data, 8'h22);
    chk("hold_cs_kept2", cs_n, 1'b0);
    wait_idle();
    step();
    chk("hold_starts", n_starts - s0, 2);
    chk("hold_cs_bursts", cs_falls - c0, 1);
    pop_all(n);
    chk("hold_rx_count", n, 2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      wr_en   = ($urandom_range(0, 9) < 3);
      wr_data = 8'($urandom);
      rd_en   = (i < 300) ? ($urandom_range(0, 9) < 1) : ($urandom_range(0, 9) < 5);
      ovf_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
    wait_idle();
    step();
    pop_all(n);
    chk("rand_drained", rx_empty, 1'b1);

    // Reset in the middle of a transfer
    push_byte(8'h77);
    push_byte(8'h88);
    k = 0;
    while (!spi_tx_start && k < 20) begin
      step();
      k++;
    end
    step();
    step();
    chk("mid_cs_low", cs_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs_n", cs_n, 1'b1);
    chk("mid_rst_rx_empty", rx_empty, 1'b1);
    chk("mid_rst_tx_full", tx_full, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_start", spi_tx_start, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("post_rst_cs_n", cs_n, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_rx_empty", rx_empty, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
